// File: rtl/rs_strobe_gen_pkg.sv
// Shared types and helpers for the RS-latch strobe front end.
// State encodings are fixed so a checker can decode the debug bus directly.
package rs_strobe_gen_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE_S = 2'd1,
    PULSE_R = 2'd2
  } state_t;

  // One millisecond of stability on the 50 MHz board clock.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/rs_strobe_gen_key_debounce.sv
// One pushbutton lane: two-flop synchroniser, stability counter and press-edge pulse.
// A key still held when reset releases must be seen released before it may produce a press.
module rs_strobe_gen_key_debounce
  import rs_strobe_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Key_n,
  output logic Level,
  output logic Press
);

  localparam int              CW   = clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_a;
  logic          sync_b;
  logic          fill_a;
  logic          fill_b;
  logic          armed;
  logic [CW-1:0] count;

  // fill_b marks that sync_b now holds a real pin sample rather than its reset value.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync_a <= 1'b1;
      sync_b <= 1'b1;
      fill_a <= 1'b0;
      fill_b <= 1'b0;
      armed  <= 1'b0;
      Level  <= 1'b1;
      count  <= '0;
      Press  <= 1'b0;
    end else begin
      sync_a <= Key_n;
      sync_b <= sync_a;
      fill_a <= 1'b1;
      fill_b <= fill_a;
      Press  <= 1'b0;
      if (fill_b && sync_b) begin
        armed <= 1'b1;
      end
      if (sync_b == Level) begin
        count <= '0;
      end else if (count == LAST) begin
        Level <= sync_b;
        count <= '0;
        Press <= armed & ~sync_b;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/rs_strobe_gen.sv
// Turns two debounced key presses into mutually exclusive, fixed-width S/R strobes.
// dbg = {state, set level, reset level} for external checkers.
module rs_strobe_gen
  import rs_strobe_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int PULSE_LEN       = 1,
  parameter bit R_PRIORITY      = 1'b1
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       KeyS_n,
  input  logic       KeyR_n,
  output logic       S,
  output logic       R,
  output logic       Busy,
  output logic       Conflict,
  output logic [3:0] dbg
);

  localparam int            PW         = clog2(PULSE_LEN) + 1;
  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_LEN - 1);

  state_t        state;
  state_t        state_d;
  logic [PW-1:0] cnt;
  logic [PW-1:0] cnt_d;
  logic          s_d;
  logic          r_d;
  logic          busy_d;
  logic          conflict_d;
  logic          press_s;
  logic          press_r;
  logic          level_s;
  logic          level_r;

  rs_strobe_gen_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_s (
    .Clk   (Clk),
    .Rst   (Rst),
    .Key_n (KeyS_n),
    .Level (level_s),
    .Press (press_s)
  );

  rs_strobe_gen_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_r (
    .Clk   (Clk),
    .Rst   (Rst),
    .Key_n (KeyR_n),
    .Level (level_r),
    .Press (press_r)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= IDLE;
      cnt      <= '0;
      S        <= 1'b0;
      R        <= 1'b0;
      Busy     <= 1'b0;
      Conflict <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      S        <= s_d;
      R        <= r_d;
      Busy     <= busy_d;
      Conflict <= conflict_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (press_s && press_r) begin
          state_d = R_PRIORITY ? PULSE_R : PULSE_S;
        end else if (press_s) begin
          state_d = PULSE_S;
        end else if (press_r) begin
          state_d = PULSE_R;
        end
      end
      PULSE_S, PULSE_R: begin
        if (cnt == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes come straight from the next state, so S and R can never both be set.
  always_comb begin
    cnt_d      = cnt;
    conflict_d = 1'b0;
    unique case (state)
      IDLE: begin
        conflict_d = press_s & press_r;
        if (press_s || press_r) begin
          cnt_d = PULSE_LAST;
        end
      end
      PULSE_S, PULSE_R: begin
        conflict_d = press_s | press_r;
        if (cnt != '0) begin
          cnt_d = cnt - PW'(1);
        end
      end
      default: cnt_d = '0;
    endcase
    s_d    = (state_d == PULSE_S);
    r_d    = (state_d == PULSE_R);
    busy_d = (state_d != IDLE);
  end

  assign dbg = {state, level_s, level_r};

endmodule

// File: tb/tb_rs_strobe_gen.sv
// Directed and random stimulus for rs_strobe_gen, checked against an edge-indexed history model
// of key samples (window-of-stability debounce, interval-based strobe timing).
module tb_rs_strobe_gen;

  localparam int DC   = 4;
  localparam int PL   = 2;
  localparam bit RP   = 1'b1;
  localparam int MAXE = 4000;

  logic       Clk    = 1'b0;
  logic       Rst    = 1'b1;
  logic       KeyS_n = 1'b1;
  logic       KeyR_n = 1'b1;
  logic       S;
  logic       R;
  logic       Busy;
  logic       Conflict;
  logic [3:0] dbg;

  always #5 Clk = ~Clk;

  rs_strobe_gen #(.DEBOUNCE_CYCLES(DC), .PULSE_LEN(PL), .R_PRIORITY(RP)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .KeyS_n   (KeyS_n),
    .KeyR_n   (KeyR_n),
    .S        (S),
    .R        (R),
    .Busy     (Busy),
    .Conflict (Conflict),
    .dbg      (dbg)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int edge_n   = 0;

  // Key history indexed by edge number: [0] = set key, [1] = reset key.
  logic key_h [0:1][0:MAXE];
  logic rst_h [0:MAXE];

  int   last_rst = 0;
  logic st    [0:1];
  int   chg   [0:1];
  logic armed [0:1];
  logic pend  [0:1];
  int   str_a = -100;
  int   str_k = 0;
  logic exp_s = 1'b0;
  logic exp_r = 1'b0;
  logic exp_c = 1'b0;

  int cnt_s, cnt_r, cnt_c;
  int first_s, first_r, first_c;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, expv, edge_n);
    end
  endtask

  // Value the synchroniser presents at edge e: the pin sampled two edges earlier, or released.
  function automatic logic sy_at(input int k, input int e);
    if (e - 2 > last_rst) return key_h[k][e-2];
    return 1'b1;
  endfunction

  task automatic model_edge();
    int   e;
    logic act;
    logic ok;
    logic arm_old;
    e = edge_n;
    if (rst_h[e]) begin
      last_rst = e;
      for (int k = 0; k < 2; k++) begin
        st[k] = 1'b1; chg[k] = e; armed[k] = 1'b0; pend[k] = 1'b0;
      end
      str_a = -100;
      exp_s = 1'b0; exp_r = 1'b0; exp_c = 1'b0;
    end else begin
      act   = (e - 1 >= str_a) && (e - 1 <= str_a + PL - 1);
      exp_c = 1'b0;
      if (act) begin
        exp_c = pend[0] | pend[1];
      end else if (pend[0] || pend[1]) begin
        str_a = e;
        if (pend[0] && pend[1]) begin
          str_k = RP ? 1 : 0;
          exp_c = 1'b1;
        end else begin
          str_k = pend[1] ? 1 : 0;
        end
      end
      exp_s = (str_k == 0) && (e >= str_a) && (e <= str_a + PL - 1);
      exp_r = (str_k == 1) && (e >= str_a) && (e <= str_a + PL - 1);
      for (int k = 0; k < 2; k++) begin
        ok = (e - chg[k] >= DC);
        for (int j = 0; j < DC; j++) begin
          if (ok && sy_at(k, e - j) == st[k]) ok = 1'b0;
        end
        arm_old = armed[k];
        pend[k] = 1'b0;
        if (ok) begin
          st[k]   = ~st[k];
          chg[k]  = e;
          pend[k] = arm_old && !st[k];
        end
        if (e - 2 > last_rst && sy_at(k, e)) armed[k] = 1'b1;
      end
    end
  endtask

  task automatic clr_obs();
    cnt_s = 0; cnt_r = 0; cnt_c = 0;
    first_s = -1; first_r = -1; first_c = -1;
  endtask

  task automatic step(input logic r, input logic ks, input logic kr);
    @(negedge Clk);
    Rst = r; KeyS_n = ks; KeyR_n = kr;
    @(posedge Clk);
    edge_n++;
    rst_h[edge_n]    = r;
    key_h[0][edge_n] = ks;
    key_h[1][edge_n] = kr;
    model_edge();
    #1;
    chk("S", {31'd0, S}, {31'd0, exp_s});
    chk("R", {31'd0, R}, {31'd0, exp_r});
    chk("Busy", {31'd0, Busy}, {31'd0, exp_s | exp_r});
    chk("Conflict", {31'd0, Conflict}, {31'd0, exp_c});
    chk("s_and_r", {31'd0, S & R}, 32'd0);
    chk("busy_eq_s_or_r", {31'd0, Busy}, {31'd0, S | R});
    if (S === 1'b1) begin cnt_s++; if (first_s < 0) first_s = edge_n; end
    if (R === 1'b1) begin cnt_r++; if (first_r < 0) first_r = edge_n; end
    if (Conflict === 1'b1) begin cnt_c++; if (first_c < 0) first_c = edge_n; end
  endtask

  initial begin
    int press_e;
    int rem_s, rem_r;
    logic ks, kr;

    // Test 1: reset, then idle.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
    clr_obs();
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1);
    chk("t1_idle_s", cnt_s, 0);
    chk("t1_idle_r", cnt_r, 0);

    // Test 2: clean set press.
    clr_obs();
    press_e = edge_n + 1;
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b1);
    chk("t2_latency", first_s - press_e, DC + 2);
    chk("t2_s_len", cnt_s, PL);
    chk("t2_r_none", cnt_r, 0);
    chk("t2_conf_none", cnt_c, 0);

    // Test 3: bouncy reset key, then held low.
    clr_obs();
    step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b1);
    press_e = edge_n + 1;
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b1);
    chk("t3_latency", first_r - press_e, DC + 2);
    chk("t3_r_len", cnt_r, PL);

    // Test 4: simultaneous press, reset wins.
    clr_obs();
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b1);
    chk("t4_r_len", cnt_r, PL);
    chk("t4_s_none", cnt_s, 0);
    chk("t4_conf_once", cnt_c, 1);
    chk("t4_conf_with_r", first_c, first_r);

    // Test 5: reset press lands during the set strobe.
    clr_obs();
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b1);
    chk("t5_s_len", cnt_s, PL);
    chk("t5_r_none", cnt_r, 0);
    chk("t5_conf_once", cnt_c, 1);

    // Test 6: reset on the first strobe cycle, key held through reset.
    clr_obs();
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 1'b1);
      if (exp_s) break;
    end
    chk("t6_strobe_started", cnt_s, 1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
    chk("t6_truncated", cnt_s, 1);
    clr_obs();
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1);
    chk("t6_held_no_strobe", cnt_s, 0);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1);
    chk("t6_repress_len", cnt_s, PL);

    // Random bouncy keys, occasional joint falls and rare resets.
    rem_s = 0; rem_r = 0; ks = 1'b1; kr = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (rem_s == 0) begin
        ks = 1'($urandom_range(0, 1));
        rem_s = (($urandom_range(0, 2) == 0) ? $urandom_range(1, 2) : $urandom_range(3, 14));
        if ($urandom_range(0, 5) == 0) begin
          kr = ks; rem_r = rem_s;
        end
      end
      if (rem_r == 0) begin
        kr = 1'($urandom_range(0, 1));
        rem_r = (($urandom_range(0, 2) == 0) ? $urandom_range(1, 2) : $urandom_range(3, 14));
      end
      step(($urandom_range(0, 299) == 0), ks, kr);
      rem_s--; rem_r--;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
